life_engine: RTL and testbench



---
 rtl/life_engine.sv | 161 ++++++++++++++++
 tb/tb_life_engine.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/life_engine.sv
// Sequential cellular automaton core: one cell per clock, double-buffered grid.
// Display reads the committed generation combinationally.
module life_engine #(
    parameter int                    COLS   = 16,
    parameter int                    ROWS   = 16,
    parameter int                    WRAP   = 0,
    parameter logic [8:0]            RULE_B = 9'b000001000,
    parameter logic [8:0]            RULE_S = 9'b000001100,
    parameter logic [COLS*ROWS-1:0]  SEED   = '0
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             step,
    input  logic                             clear,
    input  logic                             seed_load,
    input  logic [$clog2(COLS)-1:0]          rd_col,
    input  logic [$clog2(ROWS)-1:0]          rd_row,
    output logic                             rd_alive,
    output logic                             busy,
    output logic [15:0]                      gen_count,
    output logic [$clog2(COLS*ROWS+1)-1:0]   pop_count,
    output logic                             still
);
    localparam int N  = COLS * ROWS;
    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);
    localparam int IW = $clog2(N);
    localparam int PW = $clog2(N + 1);

    function automatic logic [PW-1:0] seed_pop();
        logic [PW-1:0] p;
        p = '0;
        for (int i = 0; i < N; i++) p = p + PW'(SEED[i]);
        return p;
    endfunction

    localparam logic [PW-1:0] SEED_POP = seed_pop();

    typedef enum logic [1:0] {IDLE, COMPUTE, COMMIT} state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    cur, nxt;
    logic [IW-1:0]   idx_q;
    logic [CW-1:0]   col_q;
    logic [RW-1:0]   row_q;
    logic [PW-1:0]   acc_q;
    logic            chg_q;
    logic [3:0]      nbr;
    logic            new_bit;

    // Off-grid neighbours are dead, or fold back to the opposite edge.
    function automatic logic cell_at(input logic [N-1:0] g, input int r, input int c);
        int rr;
        int cc;
        rr = r;
        cc = c;
        if (WRAP != 0) begin
            if (r < 0) rr = ROWS - 1;
            else if (r >= ROWS) rr = 0;
            if (c < 0) cc = COLS - 1;
            else if (c >= COLS) cc = 0;
        end else if (r < 0 || r >= ROWS || c < 0 || c >= COLS) begin
            return 1'b0;
        end
        return g[IW'(rr * COLS + cc)];
    endfunction

    always_comb begin
        nbr = '0;
        for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
                if (dr != 0 || dc != 0)
                    nbr = nbr + {3'b000, cell_at(cur, int'(row_q) + dr, int'(col_q) + dc)};
        new_bit = cur[idx_q] ? RULE_S[nbr] : RULE_B[nbr];
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (clear || seed_load) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (step) state_d = COMPUTE;
                COMPUTE: if (idx_q == IW'(N - 1)) state_d = COMMIT;
                COMMIT:  state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (state_q != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur       <= SEED;
            pop_count <= SEED_POP;
            gen_count <= '0;
            still     <= 1'b0;
            idx_q     <= '0;
            col_q     <= '0;
            row_q     <= '0;
            acc_q     <= '0;
            chg_q     <= 1'b0;
        end else if (clear) begin
            cur       <= '0;
            pop_count <= '0;
            gen_count <= '0;
            still     <= 1'b0;
        end else if (seed_load) begin
            cur       <= SEED;
            pop_count <= SEED_POP;
            gen_count <= '0;
            still     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (step) begin
                        idx_q <= '0;
                        col_q <= '0;
                        row_q <= '0;
                        acc_q <= '0;
                        chg_q <= 1'b0;
                    end
                end
                COMPUTE: begin
                    nxt[idx_q] <= new_bit;
                    acc_q      <= acc_q + PW'(new_bit);
                    chg_q      <= chg_q | (new_bit ^ cur[idx_q]);
                    idx_q      <= idx_q + 1'b1;
                    if (col_q == CW'(COLS - 1)) begin
                        col_q <= '0;
                        row_q <= row_q + 1'b1;
                    end else begin
                        col_q <= col_q + 1'b1;
                    end
                end
                COMMIT: begin
                    cur       <= nxt;
                    pop_count <= acc_q;
                    still     <= ~chg_q;
                    gen_count <= gen_count + 16'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_alive = 1'b0;
        if (int'(rd_col) < COLS && int'(rd_row) < ROWS)
            rd_alive = cur[IW'(int'(rd_row) * COLS + int'(rd_col))];
    end

endmodule

// File: tb/tb_life_engine.sv
// Directed bench for life_engine: five 16x16 engines with different seeds/edge
// modes share the control inputs; a whole-grid reference model feeds a scoreboard.
module tb_life_engine;
    localparam int N = 256;

    localparam logic [255:0] S_BL = (256'd1 << 84) | (256'd1 << 85) | (256'd1 << 86);
    localparam logic [255:0] S_BK = (256'd1 << 0) | (256'd1 << 1) | (256'd1 << 16) | (256'd1 << 17);
    localparam logic [255:0] S_ED = (256'd1 << 112) | (256'd1 << 128) | (256'd1 << 144);
    localparam logic [255:0] S_GL = (256'd1 << 222) | (256'd1 << 239) | (256'd1 << 253)
                                  | (256'd1 << 254) | (256'd1 << 255);

    typedef struct {
        logic [255:0] grid;
        int           pop;
        int           gen;
        logic         still;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, step, clear, seed_load;
    logic [3:0]  rd_col, rd_row;
    logic        alive [5];
    logic        busy  [5];
    logic [15:0] gen   [5];
    logic [8:0]  pop   [5];
    logic        still [5];

    logic [255:0] seeds [5];
    bit           wraps [5];
    logic [255:0] mg    [5];
    int           mgen  [5];
    logic         mstl  [5];
    logic [255:0] seen  [5];
    exp_t         sb    [$];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    life_engine #(.WRAP(0), .SEED(S_BL)) u_bl (
        .clk(clk), .reset(reset), .step(step), .clear(clear), .seed_load(seed_load),
        .rd_col(rd_col), .rd_row(rd_row), .rd_alive(alive[0]), .busy(busy[0]),
        .gen_count(gen[0]), .pop_count(pop[0]), .still(still[0]));
    life_engine #(.WRAP(0), .SEED(S_BK)) u_bk (
        .clk(clk), .reset(reset), .step(step), .clear(clear), .seed_load(seed_load),
        .rd_col(rd_col), .rd_row(rd_row), .rd_alive(alive[1]), .busy(busy[1]),
        .gen_count(gen[1]), .pop_count(pop[1]), .still(still[1]));
    life_engine #(.WRAP(0), .SEED(S_ED)) u_e0 (
        .clk(clk), .reset(reset), .step(step), .clear(clear), .seed_load(seed_load),
        .rd_col(rd_col), .rd_row(rd_row), .rd_alive(alive[2]), .busy(busy[2]),
        .gen_count(gen[2]), .pop_count(pop[2]), .still(still[2]));
    life_engine #(.WRAP(1), .SEED(S_ED)) u_e1 (
        .clk(clk), .reset(reset), .step(step), .clear(clear), .seed_load(seed_load),
        .rd_col(rd_col), .rd_row(rd_row), .rd_alive(alive[3]), .busy(busy[3]),
        .gen_count(gen[3]), .pop_count(pop[3]), .still(still[3]));
    life_engine #(.WRAP(1), .SEED(S_GL)) u_gl (
        .clk(clk), .reset(reset), .step(step), .clear(clear), .seed_load(seed_load),
        .rd_col(rd_col), .rd_row(rd_row), .rd_alive(alive[4]), .busy(busy[4]),
        .gen_count(gen[4]), .pop_count(pop[4]), .still(still[4]));

    function automatic logic [255:0] life_next(input logic [255:0] g, input bit wrap);
        logic [255:0] o;
        logic [7:0]   ix;
        int           n, rr, cc;
        o = '0;
        for (int r = 0; r < 16; r++) begin
            for (int c = 0; c < 16; c++) begin
                n = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        rr = r + dr;
                        cc = c + dc;
                        if (wrap) begin
                            rr = (rr + 16) % 16;
                            cc = (cc + 16) % 16;
                        end
                        if ((dr != 0 || dc != 0) && rr >= 0 && rr < 16 && cc >= 0 && cc < 16) begin
                            ix = 8'(rr * 16 + cc);
                            n = n + int'(g[ix]);
                        end
                    end
                end
                ix = 8'(r * 16 + c);
                o[ix] = g[ix] ? (n == 2 || n == 3) : (n == 3);
            end
        end
        return o;
    endfunction

    function automatic logic [255:0] shift11(input logic [255:0] g);
        logic [255:0] o;
        o = '0;
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                o[8'(((r + 1) % 16) * 16 + (c + 1) % 16)] = g[8'(r * 16 + c)];
        return o;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scan_all();
        for (int r = 0; r < 16; r++) begin
            for (int c = 0; c < 16; c++) begin
                rd_row = 4'(r);
                rd_col = 4'(c);
                #1;
                for (int k = 0; k < 5; k++) seen[k][8'(r * 16 + c)] = alive[k];
            end
        end
    endtask

    task automatic model_seed();
        for (int k = 0; k < 5; k++) begin
            mg[k]   = seeds[k];
            mgen[k] = 0;
            mstl[k] = 1'b0;
        end
    endtask

    task automatic check_state(input string tag);
        scan_all();
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("%s_grid%0d", tag, k), seen[k], mg[k]);
            chk($sformatf("%s_pop%0d", tag, k), 256'(pop[k]), 256'($countones(mg[k])));
            chk($sformatf("%s_gen%0d", tag, k), 256'(gen[k]), 256'(mgen[k]));
            chk($sformatf("%s_still%0d", tag, k), 256'(still[k]), 256'(mstl[k]));
            chk($sformatf("%s_busy%0d", tag, k), 256'(busy[k]), 256'(0));
        end
    endtask

    task automatic push_step();
        exp_t e;
        for (int k = 0; k < 5; k++) begin
            e.grid  = life_next(mg[k], wraps[k]);
            e.pop   = $countones(e.grid);
            e.gen   = (mgen[k] + 1) % 65536;
            e.still = (e.grid == mg[k]);
            sb.push_back(e);
            mg[k]   = e.grid;
            mgen[k] = e.gen;
            mstl[k] = e.still;
        end
    endtask

    task automatic pulse(input logic s, input logic cl, input logic sl);
        step = s;
        clear = cl;
        seed_load = sl;
        tick();
        step = 1'b0;
        clear = 1'b0;
        seed_load = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy[0] && n < 2000) begin
            n++;
            tick();
        end
        chk({tag, "_timeout"}, 256'(busy[0]), 256'(0));
    endtask

    task automatic compare_all(input string tag);
        exp_t e;
        scan_all();
        for (int k = 0; k < 5; k++) begin
            if (sb.size() == 0) begin
                chk($sformatf("%s_sb_empty%0d", tag, k), 256'(0), 256'(1));
            end else begin
                e = sb.pop_front();
                chk($sformatf("%s_grid%0d", tag, k), seen[k], e.grid);
                chk($sformatf("%s_pop%0d", tag, k), 256'(pop[k]), 256'(e.pop));
                chk($sformatf("%s_gen%0d", tag, k), 256'(gen[k]), 256'(e.gen));
                chk($sformatf("%s_still%0d", tag, k), 256'(still[k]), 256'(e.still));
            end
        end
    endtask

    initial begin
        int n;
        logic [15:0] g0;
        seeds = '{S_BL, S_BK, S_ED, S_ED, S_GL};
        wraps = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        reset = 1'b1;
        step = 1'b0;
        clear = 1'b0;
        seed_load = 1'b0;
        rd_col = '0;
        rd_row = '0;
        tick();
        tick();
        reset = 1'b0;
        model_seed();
        check_state("reset");

        // Generation 1 with exact busy window
        push_step();
        pulse(1'b1, 1'b0, 1'b0);
        chk("busy_rise", 256'(busy[0]), 256'(1));
        chk("no_early_gen", 256'(gen[0]), 256'(0));
        n = 0;
        while (busy[0] && n < 2000) begin
            n++;
            tick();
        end
        chk("busy_len", 256'(n), 256'(N + 1));
        compare_all("g1");
        chk("blinker_vert", seen[0], (256'd1 << 69) | (256'd1 << 85) | (256'd1 << 101));
        chk("blinker_pop", 256'(pop[0]), 256'(3));
        chk("block_still", 256'(still[1]), 256'(1));
        chk("edge_nowrap", seen[2], (256'd1 << 128) | (256'd1 << 129));
        chk("edge_wrap", seen[3], (256'd1 << 143) | (256'd1 << 128) | (256'd1 << 129));

        push_step();
        pulse(1'b1, 1'b0, 1'b0);
        wait_idle("g2");
        compare_all("g2");
        chk("blinker_back", seen[0], S_BL);
        chk("blinker_gen2", 256'(gen[0]), 256'(2));

        for (int s = 3; s <= 4; s++) begin
            push_step();
            pulse(1'b1, 1'b0, 1'b0);
            wait_idle($sformatf("g%0d", s));
            compare_all($sformatf("g%0d", s));
        end
        chk("glider_shift", seen[4], shift11(S_GL));
        chk("glider_pop", 256'(pop[4]), 256'(5));

        // Second step while busy must be dropped
        push_step();
        pulse(1'b1, 1'b0, 1'b0);
        repeat (9) tick();
        pulse(1'b1, 1'b0, 1'b0);
        wait_idle("g5");
        compare_all("g5");
        repeat (5) tick();
        chk("no_queued_busy", 256'(busy[0]), 256'(0));
        chk("no_queued_gen", 256'(gen[0]), 256'(5));

        // seed_load aborts mid-generation
        pulse(1'b1, 1'b0, 1'b0);
        repeat (N / 2 - 40) tick();
        g0 = gen[0];
        scan_all();
        chk("mid_busy", 256'(busy[0]), 256'(1));
        chk("mid_gen", 256'(g0), 256'(5));
        chk("mid_grid_gl", seen[4], mg[4]);
        chk("mid_grid_bl", seen[0], mg[0]);
        pulse(1'b0, 1'b0, 1'b1);
        chk("seed_busy", 256'(busy[0]), 256'(0));
        model_seed();
        check_state("seed");

        // clear beats step on the same cycle
        pulse(1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            mg[k] = '0;
            mgen[k] = 0;
            mstl[k] = 1'b0;
        end
        check_state("clear");
        repeat (3) tick();
        chk("clear_nostep", 256'(busy[0]), 256'(0));

        // Reset in the middle of a computation
        pulse(1'b0, 1'b0, 1'b1);
        model_seed();
        push_step();
        pulse(1'b1, 1'b0, 1'b0);
        wait_idle("g6");
        compare_all("g6");
        pulse(1'b1, 1'b0, 1'b0);
        repeat (50) tick();
        chk("pre_reset_busy", 256'(busy[0]), 256'(1));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_seed();
        check_state("rst_mid");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
